bit_operator_pipe: RTL

Parametrised, two-stage pipelined successor to the combinational ALU bitwise unit. Takes two WIDTH-bit operands and a 3-bit operation select under a valid/ready handshake. Returns the bitwise result, a population count mode and a zero flag two cycles later. It sits in the ALU bitwise lane and tolerates writeback backpressure without losing or duplicating operations.

---
 rtl/bitop_pkg.sv | 18 +
 rtl/bitop_stage_reg.sv | 43 ++++
 rtl/bit_operator_pipe.sv | 87 ++++++++
 3 files changed

// File: rtl/bitop_pkg.sv
// Shared definitions for the pipelined ALU bitwise lane.
// Op encodings keep the legacy codes in the low half of the map.
package bitop_pkg;

  localparam int BITOP_W = 3;

  typedef enum logic [BITOP_W-1:0] {
    OP_XOR  = 3'b000,
    OP_ZERO = 3'b001,
    OP_OR   = 3'b010,
    OP_AND  = 3'b011,
    OP_ANDN = 3'b100,
    OP_ORN  = 3'b101,
    OP_XNOR = 3'b110,
    OP_POPC = 3'b111
  } bitop_e;

endpackage

// File: rtl/bitop_stage_reg.sv
// Valid+data pipeline slice; loads when the slice is empty or drains.
// Data only moves with a valid input so bubbles leave it untouched.
module bitop_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         down_ready_i,
  output logic         adv_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign adv_o = !valid_q || down_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (adv_o) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/bit_operator_pipe.sv
// Two-stage bitwise unit: S1 does the logic op, S2 popcount and zero.
// in_ready is combinational from out_ready; there is no skid buffer.
module bit_operator_pipe
  import bitop_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   opranda,
  input  logic [WIDTH-1:0]   oprandb,
  input  logic [BITOP_W-1:0] op_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   res,
  output logic               zero
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int S1W = WIDTH + BITOP_W;
  localparam int S2W = WIDTH + 1;

  logic             s1_valid, s1_adv, s2_adv;
  logic [S1W-1:0]   s1_d, s1_q;
  logic [S2W-1:0]   s2_d, s2_q;
  logic [WIDTH-1:0] s1_res, s1_val, res_d;
  logic [CW-1:0]    cnt;
  bitop_e           op_e, s1_op;

  assign op_e = bitop_e'(op_sel);

  always_comb begin
    s1_res = '0;
    unique case (op_e)
      OP_XOR:  s1_res = opranda ^ oprandb;
      OP_ZERO: s1_res = '0;
      OP_OR:   s1_res = opranda | oprandb;
      OP_AND:  s1_res = opranda & oprandb;
      OP_ANDN: s1_res = opranda & ~oprandb;
      OP_ORN:  s1_res = opranda | ~oprandb;
      OP_XNOR: s1_res = ~(opranda ^ oprandb);
      OP_POPC: s1_res = opranda;
    endcase
  end

  assign s1_d = {op_sel, s1_res};

  bitop_stage_reg #(.W(S1W)) u_s1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (in_valid),
    .data_i       (s1_d),
    .down_ready_i (s2_adv),
    .adv_o        (s1_adv),
    .valid_o      (s1_valid),
    .data_o       (s1_q)
  );

  assign in_ready = s1_adv;
  assign s1_op    = bitop_e'(s1_q[S1W-1:WIDTH]);
  assign s1_val   = s1_q[WIDTH-1:0];

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + CW'(s1_val[i]);
  end

  assign res_d = (s1_op == OP_POPC) ? WIDTH'(cnt) : s1_val;
  assign s2_d  = {~|res_d, res_d};

  bitop_stage_reg #(.W(S2W)) u_s2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (s1_valid),
    .data_i       (s2_d),
    .down_ready_i (out_ready),
    .adv_o        (s2_adv),
    .valid_o      (out_valid),
    .data_o       (s2_q)
  );

  assign res  = s2_q[WIDTH-1:0];
  assign zero = s2_q[WIDTH];

endmodule
